word_aligner32: RTL and testbench
=================================

WORD_ALIGNER32 -- requirements
Module: word_aligner32

Interface
REQ-001 Parameter SYNC_WORD, default 32'hBC5A_3CC3, framing pattern in the first word of every frame.
REQ-002 Parameter FRAME_LEN, default 16, words per frame including the sync word; legal range 2..256.
REQ-003 Parameter LOCK_COUNT, default 4, consecutive good sync words needed to declare lock.
REQ-004 Parameter UNLOCK_COUNT, default 4, consecutive bad sync words needed to drop lock.
REQ-005 CLKBit  in  1  bit-rate clock, single clock domain, rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 WordIn  in  32  raw word from the 32-bit deserializer, MSB first in time.
REQ-008 WordValid  in  1  one-cycle strobe; WordIn is new on this cycle.
REQ-009 Enable  in  1  alignment enable; low forces the hunt state.
REQ-010 DataOut  out  32  aligned word.
REQ-011 DataValid  out  1  one-cycle strobe qualifying DataOut.
REQ-012 SyncFlag  out  1  high with DataValid when DataOut is the frame sync word.
REQ-013 Locked  out  1  high while in state LOCKED.
REQ-014 Offset  out  5  current bit-slip offset, 0..31.
REQ-015 LockLost  out  1  one-cycle pulse on the LOCKED->HUNT transition.

Function
REQ-016 On each WordValid with Enable high, the block SHALL register prev<=cur and cur<=WordIn; window = ({prev,cur} >> Offset)[31:0].
REQ-017 Offset 0 SHALL select cur unchanged; offset k SHALL select {prev[k-1:0], cur[31:k]}.
REQ-018 DataOut/DataValid SHALL be registered one CLKBit after the WordValid that completes the window, in every state.
REQ-019 FSM states: HUNT, VERIFY, LOCKED; all transitions SHALL be evaluated only on WordValid cycles, except the Enable rule.
REQ-020 HUNT: window==SYNC_WORD -> VERIFY, good_cnt=1, word_cnt=1; mismatch -> Offset=Offset+1 modulo 32 (31 wraps to 0).
REQ-021 VERIFY: word_cnt SHALL count 0..FRAME_LEN-1 and wrap; at word_cnt==0, match increments good_cnt, and good_cnt reaching LOCK_COUNT -> LOCKED.
REQ-022 VERIFY mismatch at word_cnt==0 -> HUNT with Offset+1; non-sync positions SHALL not be checked.
REQ-023 LOCKED: at word_cnt==0, mismatch increments bad_cnt; match clears bad_cnt; bad_cnt reaching UNLOCK_COUNT -> HUNT, Offset held, LockLost pulse.
REQ-024 SyncFlag SHALL be asserted for any window equal to SYNC_WORD at word_cnt==0 in VERIFY/LOCKED, and for the matching word in HUNT.
REQ-025 Enable low SHALL force HUNT, clear counters and Locked, ignore WordValid, and hold Offset; LockLost SHALL pulse if LOCKED was active.
REQ-026 WordValid on consecutive cycles SHALL be accepted; no minimum spacing.
REQ-027 Offset SHALL change only in HUNT or on a VERIFY failure, never while LOCKED.

Reset
REQ-028 RST high on a rising CLKBit edge SHALL set state=HUNT, Offset=0, prev=cur=0, counters=0, and all outputs 0.
REQ-029 RST SHALL take priority over WordValid and Enable in the same cycle; reset mid-frame SHALL discard partial alignment.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the SYNC_WORD default constant.
REQ-031 The barrel window extraction SHALL be one sub-module, word_shifter64to32 (inputs prev, cur, offset).

Verification
REQ-032 Stream with sync at bit offset 0, FRAME_LEN=16 -> Locked after 4 frames (fourth sync), Offset=0, SyncFlag once every 16 DataValid.
REQ-033 Stream delayed by 7 bits -> Offset steps 0..7 in HUNT, locks at Offset=7, DataOut on sync word equals 32'hBC5A_3CC3.
REQ-034 Locked, corrupt 3 sync words then a good one -> Locked stays 1; corrupt 4 consecutive -> LockLost pulses once, state HUNT, Offset unchanged.
REQ-035 Random data with no sync, 40 words -> Offset wraps 31->0, Locked never asserts.
REQ-036 RST asserted in LOCKED coincident with WordValid -> next cycle all outputs 0, Offset=0, HUNT.
REQ-037 Enable dropped while LOCKED -> LockLost pulse, Locked 0, subsequent WordValid produce no DataValid until Enable high.

Source files
------------

// File: rtl/word_aligner32_pkg.sv
// Shared types and constants for the 32-bit word aligner.
package word_aligner32_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] SYNC_WORD_DEF = 32'hBC5A_3CC3;

  // Width of the frame position and good/bad counters (FRAME_LEN up to 256).
  localparam int CNT_W = 8;

endpackage

// File: rtl/word_aligner32_shifter.sv
// Barrel window extraction: 32-bit slice of {prev,cur} at a bit-slip offset.
module word_shifter64to32 (
  input  logic [31:0] prev,
  input  logic [31:0] cur,
  input  logic [4:0]  offset,
  output logic [31:0] window
);

  logic [63:0] shifted;

  // Offset 0 yields cur; offset k yields {prev[k-1:0], cur[31:k]}.
  assign shifted = {prev, cur} >> offset;
  assign window  = shifted[31:0];

endmodule

// File: rtl/word_aligner32.sv
// Frame aligner: hunts bit-slip offset for SYNC_WORD, verifies, then tracks lock.
module word_aligner32
  import word_aligner32_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int          FRAME_LEN    = 16,
  parameter int          LOCK_COUNT   = 4,
  parameter int          UNLOCK_COUNT = 4
) (
  input  logic        CLKBit,
  input  logic        RST,
  input  logic [31:0] WordIn,
  input  logic        WordValid,
  input  logic        Enable,
  output logic [31:0] DataOut,
  output logic        DataValid,
  output logic        SyncFlag,
  output logic        Locked,
  output logic [4:0]  Offset,
  output logic        LockLost
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_COUNT);

  state_t           state, nxt_state;
  logic [4:0]       offset, nxt_offset;
  logic [CNT_W-1:0] word_cnt, nxt_word_cnt;
  logic [CNT_W-1:0] good_cnt, nxt_good;
  logic [CNT_W-1:0] bad_cnt, nxt_bad;
  logic [CNT_W-1:0] pos_inc;

  logic [31:0] cur;
  logic [31:0] window;
  logic [31:0] data_out;
  logic        data_valid, sync_flag, lock_lost;
  logic        take, match, at_sync_pos;

  assign take        = Enable && WordValid;
  assign at_sync_pos = (word_cnt == '0);
  assign pos_inc     = (word_cnt == LAST_POS) ? '0 : word_cnt + 1'b1;

  // The incoming word completes the window: the held word becomes prev and
  // WordIn becomes cur, so the result can be registered on this same edge.
  word_shifter64to32 u_shift (
    .prev   (cur),
    .cur    (WordIn),
    .offset (offset),
    .window (window)
  );

  assign match = (window == SYNC_WORD);

  // FSM state, offset and counter registers
  always_ff @(posedge CLKBit) begin
    if (RST) begin
      state    <= ST_HUNT;
      offset   <= '0;
      word_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= nxt_state;
      offset   <= nxt_offset;
      word_cnt <= nxt_word_cnt;
      good_cnt <= nxt_good;
      bad_cnt  <= nxt_bad;
    end
  end

  // Next-state logic: Enable low overrides everything, else act on WordValid
  always_comb begin
    nxt_state    = state;
    nxt_offset   = offset;
    nxt_word_cnt = word_cnt;
    nxt_good     = good_cnt;
    nxt_bad      = bad_cnt;
    if (!Enable) begin
      nxt_state    = ST_HUNT;
      nxt_word_cnt = '0;
      nxt_good     = '0;
      nxt_bad      = '0;
    end else if (WordValid) begin
      unique case (state)
        ST_HUNT: begin
          if (match) begin
            nxt_state    = (LOCK_C <= CNT_W'(1)) ? ST_LOCKED : ST_VERIFY;
            nxt_good     = CNT_W'(1);
            nxt_bad      = '0;
            nxt_word_cnt = CNT_W'(1);
          end else begin
            nxt_offset = offset + 5'd1;
          end
        end
        ST_VERIFY: begin
          nxt_word_cnt = pos_inc;
          if (at_sync_pos) begin
            if (match) begin
              nxt_good = good_cnt + 1'b1;
              if (good_cnt + 1'b1 >= LOCK_C) nxt_state = ST_LOCKED;
            end else begin
              nxt_state    = ST_HUNT;
              nxt_offset   = offset + 5'd1;
              nxt_word_cnt = '0;
              nxt_good     = '0;
            end
          end
        end
        ST_LOCKED: begin
          nxt_word_cnt = pos_inc;
          if (at_sync_pos) begin
            if (match) begin
              nxt_bad = '0;
            end else if (bad_cnt + 1'b1 >= UNLOCK_C) begin
              // Offset is deliberately held so re-hunt starts at the last good slip.
              nxt_state    = ST_HUNT;
              nxt_word_cnt = '0;
              nxt_good     = '0;
              nxt_bad      = '0;
            end else begin
              nxt_bad = bad_cnt + 1'b1;
            end
          end
        end
        default: nxt_state = ST_HUNT;
      endcase
    end
  end

  // Datapath: word history, aligned output, sync and lock-loss strobes
  always_ff @(posedge CLKBit) begin
    if (RST) begin
      cur        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sync_flag  <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      data_valid <= take;
      sync_flag  <= take && match && ((state == ST_HUNT) || at_sync_pos);
      lock_lost  <= (state == ST_LOCKED) && (nxt_state == ST_HUNT);
      if (take) begin
        cur      <= WordIn;
        data_out <= window;
      end
    end
  end

  assign DataOut   = data_out;
  assign DataValid = data_valid;
  assign SyncFlag  = sync_flag;
  assign Locked    = (state == ST_LOCKED);
  assign Offset    = offset;
  assign LockLost  = lock_lost;

endmodule

// File: tb/tb_word_aligner32.sv
// Directed bench for word_aligner32: lock at offset 0 and 7, loss of lock,
// offset wrap on sync-free data, reset and Enable overrides.
module tb_word_aligner32;

  localparam logic [31:0] SYNC = 32'hBC5A_3CC3;

  logic        CLKBit = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] WordIn = '0;
  logic        WordValid = 1'b0;
  logic        Enable = 1'b1;
  logic [31:0] DataOut;
  logic        DataValid, SyncFlag, Locked, LockLost;
  logic [4:0]  Offset;

  int errors = 0;
  int checks = 0;
  int step   = 0;

  always #5 CLKBit = ~CLKBit;

  word_aligner32 #(
    .SYNC_WORD    (SYNC),
    .FRAME_LEN    (16),
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (4)
  ) dut (
    .CLKBit    (CLKBit),
    .RST       (RST),
    .WordIn    (WordIn),
    .WordValid (WordValid),
    .Enable    (Enable),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .SyncFlag  (SyncFlag),
    .Locked    (Locked),
    .Offset    (Offset),
    .LockLost  (LockLost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  // One word per clock; outputs for that word are visible on return.
  task automatic push(input logic [31:0] w);
    @(negedge CLKBit);
    WordIn    = w;
    WordValid = 1'b1;
    @(posedge CLKBit);
    #1;
    WordValid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLKBit);
    RST       = 1'b1;
    WordValid = 1'b0;
    @(posedge CLKBit);
    @(negedge CLKBit);
    RST = 1'b0;
  endtask

  // Aligned word stream for the 7-bit slip test: sync at index 6 mod 16.
  function automatic logic [31:0] aw(input int i);
    if (i < 0) return 32'h0;
    if (i % 16 == 6) return SYNC;
    return 32'h0000_1000 + 32'(i);
  endfunction

  // Raw deserializer word e such that the window at offset 7 over (raw(e-1), raw(e)) is aw(e-1).
  function automatic logic [31:0] raw7(input int e);
    logic [63:0] t;
    t = {aw(e - 1), aw(e)} >> 25;
    return t[31:0];
  endfunction

  logic [31:0] w;
  bit          cor;
  int          nsync;

  initial begin
    // ---- reset state ----
    do_reset();
    chk("rst_valid", DataValid, 0);
    chk("rst_data", DataOut, 0);
    chk("rst_sync", SyncFlag, 0);
    chk("rst_locked", Locked, 0);
    chk("rst_offset", Offset, 0);
    chk("rst_lost", LockLost, 0);

    // ---- aligned stream: lock on 4th sync, then loss of lock ----
    nsync = 0;
    for (int e = 0; e <= 176; e++) begin
      step = e;
      cor = (e == 64) || (e == 80) || (e == 96) ||
            (e == 128) || (e == 144) || (e == 160) || (e == 176);
      if (e % 16 == 0) w = cor ? (SYNC ^ 32'h1) : SYNC;
      else             w = 32'h0000_1000 + 32'(e);
      push(w);
      chk("a_valid", DataValid, 1);
      chk("a_data", DataOut, w);
      chk("a_sync", SyncFlag, (e % 16 == 0) && !cor);
      chk("a_locked", Locked, (e >= 48) && (e < 176));
      chk("a_lost", LockLost, e == 176);
      chk("a_offset", Offset, 0);
      if (e < 64 && SyncFlag) nsync++;
    end
    chk("a_sync_count", nsync, 4);
    step = 177;
    push(32'h0000_2000);
    chk("a_lost_once", LockLost, 0);
    chk("a_hunt_locked", Locked, 0);

    // ---- 7-bit slip: offset hunts 0..7, locks at 7 ----
    do_reset();
    for (int e = 0; e <= 55; e++) begin
      step = 1000 + e;
      push(raw7(e));
      chk("b_offset", Offset, (e < 7) ? e + 1 : 7);
      chk("b_locked", Locked, e >= 55);
      if (e >= 7 && (e - 7) % 16 == 0) begin
        chk("b_sync", SyncFlag, 1);
        chk("b_data", DataOut, SYNC);
      end
    end

    // ---- reset coincident with WordValid while locked ----
    step = 1056;
    @(negedge CLKBit);
    RST       = 1'b1;
    WordIn    = raw7(56);
    WordValid = 1'b1;
    @(posedge CLKBit);
    #1;
    chk("r_valid", DataValid, 0);
    chk("r_data", DataOut, 0);
    chk("r_sync", SyncFlag, 0);
    chk("r_locked", Locked, 0);
    chk("r_offset", Offset, 0);
    chk("r_lost", LockLost, 0);
    @(negedge CLKBit);
    RST       = 1'b0;
    WordValid = 1'b0;

    // ---- sync-free data: offset wraps, never locks ----
    do_reset();
    for (int e = 0; e < 40; e++) begin
      step = 2000 + e;
      push($urandom);
      chk("d_offset", Offset, (e + 1) % 32);
      chk("d_locked", Locked, 0);
    end

    // ---- Enable dropped while locked ----
    do_reset();
    for (int e = 0; e <= 48; e++) begin
      step = 3000 + e;
      push((e % 16 == 0) ? SYNC : 32'h0000_3000 + 32'(e));
    end
    chk("e_locked", Locked, 1);
    step = 3049;
    @(negedge CLKBit);
    Enable = 1'b0;
    @(posedge CLKBit);
    #1;
    chk("e_lost", LockLost, 1);
    chk("e_locked_off", Locked, 0);
    for (int e = 0; e < 3; e++) begin
      step = 3050 + e;
      push(SYNC);
      chk("e_no_valid", DataValid, 0);
      chk("e_lost_clr", LockLost, 0);
      chk("e_offset", Offset, 0);
    end
    @(negedge CLKBit);
    Enable = 1'b1;
    step = 3053;
    push(SYNC);
    chk("e_valid_back", DataValid, 1);
    chk("e_sync_back", SyncFlag, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
